// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with stall hold, flush, valid tracking, load-use hazard
// detection and automatic bubble insertion with a saturating bubble counter.
module id_ex_stage_reg #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned REG_W       = 5,
    parameter int unsigned WB_W        = 2,
    parameter int unsigned M_W         = 3,
    parameter int unsigned EX_W        = 6,
    parameter int unsigned MEMREAD_BIT = 0,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] pc_i,
    input  logic [DATA_W-1:0] read_data1_i,
    input  logic [DATA_W-1:0] read_data2_i,
    input  logic [DATA_W-1:0] sign_ext_i,
    input  logic [REG_W-1:0]  rs_i,
    input  logic [REG_W-1:0]  rt_i,
    input  logic [REG_W-1:0]  rd_i,
    input  logic [WB_W-1:0]   ctrl_wb_i,
    input  logic [M_W-1:0]    ctrl_m_i,
    input  logic [EX_W-1:0]   ctrl_ex_i,
    output logic [DATA_W-1:0] pc_o,
    output logic [DATA_W-1:0] read_data1_o,
    output logic [DATA_W-1:0] read_data2_o,
    output logic [DATA_W-1:0] sign_ext_o,
    output logic [REG_W-1:0]  rs_o,
    output logic [REG_W-1:0]  rt_o,
    output logic [REG_W-1:0]  rd_o,
    output logic [WB_W-1:0]   ctrl_wb_o,
    output logic [M_W-1:0]    ctrl_m_o,
    output logic [EX_W-1:0]   ctrl_ex_o,
    output logic              valid_o,
    output logic              hazard_stall_o,
    output logic [CNT_W-1:0]  bubble_count_o
);

    logic [DATA_W-1:0] pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, se_q, se_d;
    logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
    logic [WB_W-1:0]   wb_q, wb_d;
    logic [M_W-1:0]    m_q, m_d;
    logic [EX_W-1:0]   ex_q, ex_d;
    logic              valid_q, valid_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              hazard;

    // $zero is never a real dependency, so rt == 0 cannot raise a hazard.
    assign hazard = valid_q & m_q[MEMREAD_BIT] & valid_i & (rt_q != '0)
                  & ((rt_q == rs_i) | (rt_q == rt_i)) & ~flush_i;

    always_comb begin
        pc_d    = pc_q;
        rd1_d   = rd1_q;
        rd2_d   = rd2_q;
        se_d    = se_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        wb_d    = wb_q;
        m_d     = m_q;
        ex_d    = ex_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
            wb_d    = '0;
            m_d     = '0;
            ex_d    = '0;
        end else if (stall_i) begin
            // Hold everything; a pending hazard is re-evaluated once the stall drops.
        end else if (hazard) begin
            valid_d = 1'b0;
            wb_d    = '0;
            m_d     = '0;
            ex_d    = '0;
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            pc_d    = pc_i;
            rd1_d   = read_data1_i;
            rd2_d   = read_data2_i;
            se_d    = sign_ext_i;
            rs_d    = rs_i;
            rt_d    = rt_i;
            rd_d    = rd_i;
            wb_d    = ctrl_wb_i;
            m_d     = ctrl_m_i;
            ex_d    = ctrl_ex_i;
            valid_d = valid_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            se_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            wb_q    <= '0;
            m_q     <= '0;
            ex_q    <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            se_q    <= se_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            wb_q    <= wb_d;
            m_q     <= m_d;
            ex_q    <= ex_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_o           = pc_q;
    assign read_data1_o   = rd1_q;
    assign read_data2_o   = rd2_q;
    assign sign_ext_o     = se_q;
    assign rs_o           = rs_q;
    assign rt_o           = rt_q;
    assign rd_o           = rd_q;
    assign ctrl_wb_o      = wb_q;
    assign ctrl_m_o       = m_q;
    assign ctrl_ex_o      = ex_q;
    assign valid_o        = valid_q;
    assign hazard_stall_o = hazard;
    assign bubble_count_o = cnt_q;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: a behavioural model pushes expected EX-stage
// state into a scoreboard queue, popped and compared after each clock edge.
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic [31:0] pc, rd1, rd2, se;
        logic [4:0]  rs, rt, rd;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [5:0]  ex;
        logic        valid;
    } in_t;

    typedef struct packed {
        logic [31:0] pc, rd1, rd2, se;
        logic [4:0]  rs, rt, rd;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic [5:0]  ex;
        logic        valid;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
    } st_t;

    logic clk = 1'b0, run = 1'b0;
    logic rst, stall, flush;
    in_t  in;
    st_t  mdl;
    st_t  exp_q[$];
    int   n_tests = 0, n_fail = 0;

    logic [31:0] pc_o, rd1_o, rd2_o, se_o, pc2_o, rd12_o, rd22_o, se2_o;
    logic [4:0]  rs_o, rt_o, rd_o, rs2_o, rt2_o, rd2r_o;
    logic [1:0]  wb_o, wb2_o;
    logic [2:0]  m_o, m2_o;
    logic [5:0]  ex_o, ex2_o;
    logic        valid_o, valid2_o, hz_o, hz2_o;
    logic [15:0] cnt_o;
    logic [1:0]  cnt2_o;

    always #5 clk = run ? ~clk : clk;

    id_ex_stage_reg dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(in.valid),
        .pc_i(in.pc), .read_data1_i(in.rd1), .read_data2_i(in.rd2), .sign_ext_i(in.se),
        .rs_i(in.rs), .rt_i(in.rt), .rd_i(in.rd), .ctrl_wb_i(in.wb), .ctrl_m_i(in.m),
        .ctrl_ex_i(in.ex), .pc_o(pc_o), .read_data1_o(rd1_o), .read_data2_o(rd2_o),
        .sign_ext_o(se_o), .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .ctrl_wb_o(wb_o),
        .ctrl_m_o(m_o), .ctrl_ex_o(ex_o), .valid_o(valid_o), .hazard_stall_o(hz_o),
        .bubble_count_o(cnt_o)
    );

    id_ex_stage_reg #(.CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush), .valid_i(in.valid),
        .pc_i(in.pc), .read_data1_i(in.rd1), .read_data2_i(in.rd2), .sign_ext_i(in.se),
        .rs_i(in.rs), .rt_i(in.rt), .rd_i(in.rd), .ctrl_wb_i(in.wb), .ctrl_m_i(in.m),
        .ctrl_ex_i(in.ex), .pc_o(pc2_o), .read_data1_o(rd12_o), .read_data2_o(rd22_o),
        .sign_ext_o(se2_o), .rs_o(rs2_o), .rt_o(rt2_o), .rd_o(rd2r_o), .ctrl_wb_o(wb2_o),
        .ctrl_m_o(m2_o), .ctrl_ex_o(ex2_o), .valid_o(valid2_o), .hazard_stall_o(hz2_o),
        .bubble_count_o(cnt2_o)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input string tag, input st_t e);
        chk({tag, " datapath"}, {pc_o, rd1_o, rd2_o, se_o, rs_o, rt_o, rd_o},
            {e.pc, e.rd1, e.rd2, e.se, e.rs, e.rt, e.rd});
        chk({tag, " ctrl"}, {wb_o, m_o, ex_o}, {e.wb, e.m, e.ex});
        chk({tag, " valid"}, valid_o, e.valid);
        chk({tag, " count"}, cnt_o, e.cnt);
        chk({tag, " count_sat"}, {cnt2_o, valid2_o, wb2_o, m2_o, ex2_o, pc2_o, rt2_o},
            {e.cnt2, e.valid, e.wb, e.m, e.ex, e.pc, e.rt});
    endtask

    task automatic set_in(input logic [31:0] pc, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [1:0] wb, input logic [2:0] m,
                          input logic [5:0] ex, input logic v);
        in.pc = pc; in.rs = rs; in.rt = rt; in.rd = rd;
        in.wb = wb; in.m = m; in.ex = ex; in.valid = v;
        in.rd1 = $urandom; in.rd2 = $urandom; in.se = $urandom;
    endtask

    // One clock: check combinational hazard, advance model, compare after the edge.
    task automatic step(input string tag);
        logic hz;
        st_t  e;
        #1;
        hz = mdl.valid & mdl.m[0] & in.valid & (mdl.rt != 5'd0)
           & ((mdl.rt == in.rs) | (mdl.rt == in.rt)) & ~flush;
        chk({tag, " hazard"}, {hz2_o, hz_o}, {hz, hz});
        if (flush) begin
            mdl.valid = 1'b0; mdl.wb = '0; mdl.m = '0; mdl.ex = '0;
        end else if (stall) begin
            mdl = mdl;
        end else if (hz) begin
            mdl.valid = 1'b0; mdl.wb = '0; mdl.m = '0; mdl.ex = '0;
            if (mdl.cnt != 16'hffff) mdl.cnt = mdl.cnt + 16'd1;
            if (mdl.cnt2 != 2'b11) mdl.cnt2 = mdl.cnt2 + 2'd1;
        end else begin
            mdl.pc = in.pc; mdl.rd1 = in.rd1; mdl.rd2 = in.rd2; mdl.se = in.se;
            mdl.rs = in.rs; mdl.rt = in.rt; mdl.rd = in.rd;
            mdl.wb = in.wb; mdl.m = in.m; mdl.ex = in.ex; mdl.valid = in.valid;
        end
        exp_q.push_back(mdl);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk_state(tag, e);
    endtask

    initial begin
        // Reset with nonzero inputs and no clock edges.
        stall = 1'b1; flush = 1'b1; rst = 1'b1;
        set_in(32'hdead_beef, 5'd3, 5'd4, 5'd5, 2'b11, 3'b111, 6'h3f, 1'b1);
        mdl = '0;
        #2;
        chk("reset hazard", hz_o, 1'b0);
        chk_state("reset", mdl);
        stall = 1'b0; flush = 1'b0;
        #1 rst = 1'b0;
        run = 1'b1;

        // Plain load: all controls set, this is a lw with rt=9.
        set_in(32'h0040_0004, 5'd8, 5'd9, 5'd10, 2'b11, 3'b111, 6'h3f, 1'b1);
        step("load");

        // Load-use: ID reads r9 -> bubble, then the ID instruction loads.
        set_in(32'h0040_0008, 5'd9, 5'd3, 5'd11, 2'b10, 3'b000, 6'h21, 1'b1);
        step("hazard bubble");
        step("after bubble");

        // lw with rt=0 in EX never creates a dependency.
        set_in(32'h0040_000c, 5'd1, 5'd0, 5'd0, 2'b11, 3'b001, 6'h01, 1'b1);
        step("lw rt0");
        set_in(32'h0040_0010, 5'd0, 5'd0, 5'd12, 2'b10, 3'b000, 6'h22, 1'b1);
        step("rt0 no hazard");

        // Stall with a pending hazard: outputs frozen, hazard visible, no count.
        set_in(32'h0040_0014, 5'd2, 5'd5, 5'd0, 2'b11, 3'b001, 6'h05, 1'b1);
        step("lw r5");
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(32'h0040_0018 + 32'(4 * i), 5'd5, 5'(i), 5'd13, 2'b10, 3'b010, 6'h2a, 1'b1);
            step($sformatf("stall %0d", i));
        end
        flush = 1'b1;
        step("stall+flush");
        stall = 1'b0; flush = 1'b0;

        // Flush over a hazard condition: bubble, but not counted.
        set_in(32'h0040_0030, 5'd6, 5'd6, 5'd0, 2'b11, 3'b001, 6'h07, 1'b1);
        step("lw r6");
        flush = 1'b1;
        step("flush hides hazard");
        flush = 1'b0;

        // Back-to-back dependent loads on r7: alternating bubble/load, 5 bubbles.
        set_in(32'h0040_0040, 5'd7, 5'd7, 5'd0, 2'b11, 3'b001, 6'h09, 1'b1);
        for (int i = 0; i < 11; i++) step($sformatf("chain %0d", i));

        // Async reset while a hazard is pending, then a normal load.
        set_in(32'h0040_0050, 5'd7, 5'd1, 5'd2, 2'b01, 3'b000, 6'h11, 1'b1);
        #1;
        chk("pre-reset hazard", hz_o, mdl.valid & mdl.m[0]);
        rst = 1'b1;
        #1;
        mdl = '0;
        chk("mid reset hazard", hz_o, 1'b0);
        chk_state("mid reset", mdl);
        rst = 1'b0;
        step("load after reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
